shreg_tx: RTL and testbench

SHREG_TX -- requirements
Module: shreg_tx

---
 rtl/shreg_tx.sv | 93 +++++++++
 tb/tb_shreg_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/shreg_tx.sv
// shreg_tx: serialises parallel words to an external shift register with sclk, MSB-first data and a latch strobe.
module shreg_tx #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              busy_o,
    output logic              sclk_o,
    output logic              sdat_o,
    output logic              ltch_o
);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    typedef enum logic [2:0] {IDLE, LO, HI, LTCH, GAP} state_t;
    state_t            state;
    logic [DATA_W-1:0] shreg, pend, shl, nxt;
    logic              pend_vld, expire;
    logic [BW-1:0]     bits;
    logic [DW-1:0]     div;
    assign expire = div == DW'(CLK_DIV - 1);
    assign shl    = shreg << 1;
    assign nxt    = pend_vld ? pend : data_i;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            shreg    <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            bits     <= '0;
            div      <= '0;
            busy_o   <= 1'b0;
            sclk_o   <= 1'b0;
            sdat_o   <= 1'b0;
            ltch_o   <= 1'b0;
        end else begin
            if (wr_i && state != IDLE) begin
                pend     <= data_i;
                pend_vld <= 1'b1;
            end
            div <= expire ? '0 : div + DW'(1);
            case (state)
                IDLE: begin
                    div <= '0;
                    if (wr_i) begin
                        shreg  <= data_i;
                        bits   <= BW'(DATA_W);
                        sdat_o <= data_i[DATA_W-1];
                        busy_o <= 1'b1;
                        state  <= LO;
                    end
                end
                LO: if (expire) begin
                    sclk_o <= 1'b1;
                    state  <= HI;
                end
                HI: if (expire) begin
                    shreg  <= shl;
                    bits   <= bits - BW'(1);
                    sclk_o <= 1'b0;
                    if (bits == BW'(1)) begin
                        sdat_o <= 1'b0;
                        ltch_o <= 1'b1;
                        state  <= LTCH;
                    end else begin
                        sdat_o <= shl[DATA_W-1];
                        state  <= LO;
                    end
                end
                LTCH: if (expire) begin
                    ltch_o <= 1'b0;
                    state  <= GAP;
                end
                GAP: if (expire) begin
                    // a write landing on the exit cycle either queues behind the pending word or starts directly
                    if (pend_vld || wr_i) begin
                        shreg    <= nxt;
                        bits     <= BW'(DATA_W);
                        sdat_o   <= nxt[DATA_W-1];
                        pend_vld <= pend_vld && wr_i;
                        state    <= LO;
                    end else begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shreg_tx.sv
// tb_shreg_tx: directed checks of shreg_tx waveforms (8-bit/div-2 and 1-bit/div-1 instances).
module tb_shreg_tx;
    logic clk = 1'b0, rst_n = 1'b0;
    logic wr_a = 1'b0, wr_b = 1'b0;
    logic [7:0] data_a = '0;
    logic [0:0] data_b = '0;
    logic busy_a, sclk_a, sdat_a, ltch_a, busy_b, sclk_b, sdat_b, ltch_b;
    logic [127:0] t_sclk, t_ltch, t_busy, t_sdat, u_sclk, u_ltch, u_busy, u_sdat;
    logic [127:0] e_sclk, e_ltch, e_busy;
    logic [31:0] word;
    int n, edges, bad, n_chk = 0, n_err = 0;

    shreg_tx #(.DATA_W(8), .CLK_DIV(2)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .wr_i(wr_a), .data_i(data_a),
        .busy_o(busy_a), .sclk_o(sclk_a), .sdat_o(sdat_a), .ltch_o(ltch_a)
    );
    shreg_tx #(.DATA_W(1), .CLK_DIV(1)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .wr_i(wr_b), .data_i(data_b),
        .busy_o(busy_b), .sclk_o(sclk_b), .sdat_o(sdat_b), .ltch_o(ltch_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        t_sclk[n] = sclk_a; t_ltch[n] = ltch_a; t_busy[n] = busy_a; t_sdat[n] = sdat_a;
        u_sclk[n] = sclk_b; u_ltch[n] = ltch_b; u_busy[n] = busy_b; u_sdat[n] = sdat_b;
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic clear();
        n = 0;
        {t_sclk, t_ltch, t_busy, t_sdat, u_sclk, u_ltch, u_busy, u_sdat} = '0;
        {e_sclk, e_ltch, e_busy} = '0;
    endtask

    // expected 8-bit/div-2 frame whose LO phase starts at cycle s; `bits` limits how many sclk pulses appear
    task automatic add_frame(input int s, input int nb, input bit full);
        for (int k = 0; k < nb; k++) begin
            e_sclk[s + 4*k + 2] = 1'b1;
            e_sclk[s + 4*k + 3] = 1'b1;
        end
        if (full) begin
            e_ltch[s + 32] = 1'b1;
            e_ltch[s + 33] = 1'b1;
        end
    endtask

    task automatic busy_span(input int a, input int b);
        for (int c = a; c <= b; c++) e_busy[c] = 1'b1;
    endtask

    task automatic rx(input logic [127:0] sc, input logic [127:0] sd, output logic [31:0] w,
                      output int e, output int v);
        w = '0; e = 0; v = 0;
        for (int c = 1; c < n; c++) begin
            if (sc[c] && !sc[c-1]) begin
                w = {w[30:0], sd[c]};
                e++;
            end
            if (sc[c] && sd[c] != sd[c-1]) v++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outs_a", {busy_a, sclk_a, sdat_a, ltch_a}, 4'b0);
        chk("rst_outs_b", {busy_b, sclk_b, sdat_b, ltch_b}, 4'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        clear();
        for (int c = 0; c < 40; c++) begin
            wr_a = (c == 0); data_a = 8'hA5;
            cyc();
        end
        add_frame(1, 8, 1); busy_span(1, 36);
        chk("single_sclk", t_sclk, e_sclk);
        chk("single_ltch", t_ltch, e_ltch);
        chk("single_busy", t_busy, e_busy);
        rx(t_sclk, t_sdat, word, edges, bad);
        chk("single_word", word, 32'hA5);
        chk("single_edges", edges, 8);
        chk("single_stable", bad, 0);

        clear();
        for (int c = 0; c < 80; c++) begin
            wr_a = (c == 0) || (c == 10); data_a = (c == 0) ? 8'h3C : 8'hC3;
            cyc();
        end
        add_frame(1, 8, 1); add_frame(37, 8, 1); busy_span(1, 72);
        chk("b2b_sclk", t_sclk, e_sclk);
        chk("b2b_ltch", t_ltch, e_ltch);
        chk("b2b_busy", t_busy, e_busy);
        rx(t_sclk, t_sdat, word, edges, bad);
        chk("b2b_word", word, 32'h3CC3);
        chk("b2b_edges", edges, 16);
        chk("b2b_stable", bad, 0);

        clear();
        for (int c = 0; c < 80; c++) begin
            wr_a = (c == 0) || (c == 5) || (c == 6);
            data_a = (c == 0) ? 8'h11 : (c == 5) ? 8'h22 : 8'h33;
            cyc();
        end
        add_frame(1, 8, 1); add_frame(37, 8, 1); busy_span(1, 72);
        chk("ovw_sclk", t_sclk, e_sclk);
        chk("ovw_busy", t_busy, e_busy);
        rx(t_sclk, t_sdat, word, edges, bad);
        chk("ovw_word", word, 32'h1133);
        chk("ovw_edges", edges, 16);

        clear();
        for (int c = 0; c < 60; c++) begin
            if (c == 15) rst_n = 1'b0;
            if (c == 18) rst_n = 1'b1;
            wr_a = (c == 0) || (c == 18); data_a = (c == 0) ? 8'h5A : 8'hFF;
            cyc();
            if (c == 15) chk("rst_mid_outs", {t_busy[15], t_sclk[15], t_sdat[15], t_ltch[15]}, 4'b0);
        end
        add_frame(1, 3, 0); add_frame(19, 8, 1); busy_span(1, 14); busy_span(19, 54);
        chk("rst_sclk", t_sclk, e_sclk);
        chk("rst_ltch", t_ltch, e_ltch);
        chk("rst_busy", t_busy, e_busy);
        rx(t_sclk, t_sdat, word, edges, bad);
        chk("rst_word", word, 32'h2FF);
        chk("rst_edges", edges, 11);

        clear();
        wr_a = 1'b0;
        for (int c = 0; c < 12; c++) begin
            wr_b = (c == 0); data_b = 1'b1;
            cyc();
        end
        chk("w1_sclk", u_sclk, 128'h4);
        chk("w1_ltch", u_ltch, 128'h8);
        chk("w1_busy", u_busy, 128'h1E);
        chk("w1_sdat", u_sdat, 128'h6);

        clear();
        for (int c = 0; c < 24; c++) begin
            wr_b = 1'b1; data_b = 1'b1;
            cyc();
        end
        for (int k = 0; k < 6; k++) begin
            e_sclk[4*k + 2] = 1'b1;
            e_ltch[4*k + 3] = 1'b1;
        end
        busy_span(1, 23);
        chk("hold_sclk", u_sclk, e_sclk);
        chk("hold_ltch", u_ltch, e_ltch);
        chk("hold_busy", u_busy, e_busy);
        wr_b = 1'b0;
        for (int c = 0; c < 20 && busy_b; c++) cyc();
        chk("hold_drain", busy_b, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
